fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, InstrD value whenever ValidD is low.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: sampled on the rising edge of clk, asserted when 0.
REQ-005 imem_req  output  1  instruction fetch request, one cycle per request.
REQ-006 imem_addr  output  32  fetch address, valid while imem_req is high.
REQ-007 imem_rvalid  input  1  response strobe for the single outstanding request.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 PCSrcE  input  1  redirect request from execute (taken branch or jump).
REQ-010 PCTargetE  input  32  redirect target.
REQ-011 StallD  input  1  decode stall from the hazard unit; holds the decode register.
REQ-012 InstrD  output  32  decode-register instruction.
REQ-013 PCD  output  32  PC of InstrD.
REQ-014 PCPlus4D  output  32  PCD + 4.
REQ-015 ValidD  output  1  decode register holds a live instruction.

Function
REQ-016 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, instr}, a decode register (InstrD/PCD/PCPlus4D/ValidD) and a 3-state FSM: IDLE, WAIT, DROP.
REQ-017 The block SHALL allow at most one outstanding imem request; WAIT means a request is outstanding, and DROP means an outstanding response is to be discarded.
REQ-018 imem_req SHALL assert when PCSrcE=0, the state is IDLE or the state is WAIT/DROP with imem_rvalid=1, and the FIFO's next-cycle occupancy (current count + accepted response - pop) < 2.
REQ-019 imem_addr SHALL equal the fetch PC; on each issued request, the PC SHALL advance by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and the state SHALL become WAIT.
REQ-020 In WAIT, imem_rvalid SHALL push {request PC, imem_rdata} into the FIFO; if no new request issues that cycle, the state SHALL become IDLE.
REQ-021 In DROP, imem_rvalid SHALL discard the data; the state SHALL become IDLE, or WAIT if a new request issues that cycle.
REQ-022 imem_rvalid SHALL be ignored in IDLE.
REQ-023 The decode register SHALL load the FIFO head (pop) when the FIFO is non-empty and (StallD=0 or ValidD=0); PCPlus4D SHALL be pc+4.
REQ-024 When it is not loaded and StallD=0, ValidD SHALL go to 0 with InstrD=NOP_INSTR; with StallD=1 and ValidD=1, the decode register SHALL hold.
REQ-025 Latency SHALL be: request in cycle N, response in cycle N+k, ValidD high in cycle N+k+2 (FIFO empty, no stall); with k=1 and no stalls, sustained throughput SHALL be one instruction per cycle.
REQ-026 When PCSrcE=1, in the same edge: fetch PC <= {PCTargetE[31:2],2'b00}; FIFO cleared; ValidD <= 0 and InstrD <= NOP_INSTR, regardless of StallD; no request issued.
REQ-027 On that redirect edge, the state SHALL become DROP if in WAIT without imem_rvalid, otherwise IDLE; any response arriving in that cycle SHALL be discarded.
REQ-028 A full FIFO with StallD=1 SHALL suppress requests indefinitely without loss or duplication of instructions.
REQ-029 FIFO pointers SHALL wrap modulo 2; a simultaneous push and pop on a full FIFO SHALL NOT occur (prevented by REQ-018); a simultaneous push and pop on a 1-entry FIFO SHALL keep count 1.

Reset
REQ-030 With rst=0 at an edge: PC=RESET_PC; FIFO empty; state IDLE; ValidD=0; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; imem_req=0 during reset cycles.
REQ-031 Reset SHALL override redirect, stall and responses; an in-flight response returning after reset release SHALL be ignored per REQ-022.

Verification
REQ-032 Reset release, 1-cycle memory returning addr-indexed words -> imem_addr 0,4,8... on consecutive cycles; ValidD first high 3 cycles after the first request with PCD=0, PCPlus4D=4.
REQ-033 StallD=1 for 5 cycles in steady streaming -> decode register holds; FIFO fills to 2; imem_req low; on release, PCD continues with no skipped or repeated address.
REQ-034 PCSrcE=1, PCTargetE=32'h0000_0102, while a request is outstanding -> next imem_addr=32'h0000_0100 after the stale response is dropped; ValidD=0 for the flush cycle; stale word never reaches InstrD.
REQ-035 Redirect and StallD=1 in the same cycle -> ValidD=0 next cycle; InstrD=32'h0000_0013.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4D of the FFFF_FFFC instruction = 0.
REQ-037 rst=0 for one cycle mid-stream with a response pending -> all outputs at reset values; the late imem_rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: one-outstanding imem requester, 2-entry {pc, instr} buffer and decode register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     imem,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic        w_busy;
    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic [1:0]  w_count_nxt;

    assign w_busy = (r_state == S_WAIT) || (r_state == S_DROP);

    // Push/pop/issue decisions and next FSM state; a redirect or reset blocks all of them.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        if (rst && !PCSrcE) begin
            w_push      = (r_state == S_WAIT) && imem.imem_rvalid;
            w_pop       = (r_count != 2'd0) && (!StallD || !r_valid_d);
            w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
            w_issue     = ((r_state == S_IDLE) || (w_busy && imem.imem_rvalid)) &&
                          (w_count_nxt < 2'd2);
        end else begin
            w_count_nxt = r_count;
        end
        if (PCSrcE) begin
            w_state_nxt = ((r_state == S_WAIT) && !imem.imem_rvalid) ? S_DROP : S_IDLE;
        end else if (w_issue) begin
            w_state_nxt = S_WAIT;
        end else if (w_busy && imem.imem_rvalid) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = r_pc;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC, request PC and 2-entry buffer; a push only ever lands on a buffer holding at most one entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (PCSrcE) begin
            r_pc    <= {PCTargetE[31:2], 2'b00};
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_issue) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
            if (w_push) begin
                r_fifo_pc[r_wptr]    <= r_req_pc;
                r_fifo_instr[r_wptr] <= imem.imem_rdata;
                r_wptr               <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Decode register: flush on redirect, load on pop, bubble when not stalled, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else if (PCSrcE) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (w_pop) begin
            r_instr_d   <= r_fifo_instr[r_rptr];
            r_pc_d      <= r_fifo_pc[r_rptr];
            r_pcplus4_d <= r_fifo_pc[r_rptr] + 32'd4;
            r_valid_d   <= 1'b1;
        end else if (!StallD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else begin
            r_valid_d <= r_valid_d;
        end
    end

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pcplus4_d;
    assign ValidD   = r_valid_d;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench: variable-latency imem model plus an in-order {pc, instr} scoreboard.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_if bus ();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (bus),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .StallD   (StallD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] exp_fetch_pc = RST_PC;
    logic [63:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            @(negedge clk);
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("req_seen", {31'd0, found}, 32'd1);
    endtask

    // Memory model: answer the latched request after 'lat' cycles.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        forever begin
            step();
            if (mem_cnt == 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_addr);
            end else begin
                bus.imem_rvalid = 1'b0;
            end
            if (mem_cnt != 0) mem_cnt--;
        end
    end

    // Monitor: check consumed decode entries, flush on redirect/reset, record new requests.
    initial begin
        logic [63:0] ent;
        forever begin
            @(negedge clk);
            if (ValidD === 1'b1 && StallD === 1'b0) begin
                chk("sb_avail", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    ent = sb_q.pop_front();
                    chk("sb_pcd", PCD, ent[63:32]);
                    chk("sb_instr", InstrD, ent[31:0]);
                    chk("sb_pcplus4", PCPlus4D, ent[63:32] + 32'd4);
                end
            end
            if (!rst || PCSrcE) begin
                sb_q.delete();
                exp_fetch_pc = !rst ? RST_PC : {PCTargetE[31:2], 2'b00};
            end
            if (bus.imem_req === 1'b1) begin
                chk("fetch_addr", bus.imem_addr, exp_fetch_pc);
                sb_q.push_back({exp_fetch_pc, mem_word(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                mem_cnt  = lat;
                mem_addr = bus.imem_addr;
            end
        end
    end

    initial begin
        logic        found;
        logic [31:0] held;
        int          nv;
        rst       = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'd0;
        StallD    = 1'b0;

        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_pcplus4", PCPlus4D, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        step();
        rst = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, RST_PC);
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            @(negedge clk);
            if (ValidD && !found) begin
                found = 1'b1;
                chk("valid_latency", i, 32'd3);
                chk("first_pcd", PCD, RST_PC);
                chk("first_pcplus4", PCPlus4D, RST_PC + 32'd4);
            end
        end
        chk("valid_seen", {31'd0, found}, 32'd1);

        nv = 0;
        repeat (6) begin
            step();
            @(negedge clk);
            nv += int'(ValidD);
        end
        chk("throughput", nv, 32'd6);

        step();
        StallD = 1'b1;
        @(negedge clk);
        held = PCD;
        for (int i = 1; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("stall_hold_pcd", PCD, held);
            chk("stall_valid", {31'd0, ValidD}, 32'd1);
            if (i >= 2) chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
        end
        step();
        StallD = 1'b0;
        repeat (6) step();

        lat = 2;
        wait_req();
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0102;
        @(negedge clk);
        chk("redir_no_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        PCSrcE = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, ValidD}, 32'd0);
        chk("flush_instr", InstrD, NOP);
        chk("redir_req", {31'd0, bus.imem_req}, 32'd1);
        chk("redir_addr", bus.imem_addr, 32'h0000_0100);
        repeat (10) step();

        lat = 1;
        repeat (4) step();
        step();
        PCSrcE    = 1'b1;
        StallD    = 1'b1;
        PCTargetE = 32'h0000_0200;
        step();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        @(negedge clk);
        chk("rs_valid", {31'd0, ValidD}, 32'd0);
        chk("rs_instr", InstrD, NOP);
        repeat (8) step();

        lat = 2;
        wait_req();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", {31'd0, ValidD}, 32'd0);
        chk("mrst_instr", InstrD, NOP);
        chk("mrst_pcd", PCD, 32'd0);
        chk("mrst_pcplus4", PCPlus4D, 32'd0);
        chk("mrst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("mrst_addr", bus.imem_addr, RST_PC);
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
